// File: rtl/dm_pkg.sv
// Debug module types shared by the DMI access path.
// Covers DMI request/response, DTM opcodes, dmistat error codes, the
// 41-bit DMI data register layout and the access controller state encoding.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2,
        DTM_PASS  = 2'h3
    } dtm_op_e;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    typedef enum logic [1:0] {
        DMINoError      = 2'h0,
        DMIReservedFail = 2'h1,
        DMIFailed       = 2'h2,
        DMIBusy         = 2'h3
    } dmi_error_e;

    // Layout of the DMI data register as shifted in by the TAP.
    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
        dtm_op_e     op;
    } dmi_dr_t;

    localparam int unsigned DmiDrWidth = 41;

    // Access controller FSM encoding; state_q of the controller uses this
    // type so checkers can observe it directly.
    typedef enum logic [2:0] {
        Idle           = 3'd0,
        Read           = 3'd1,
        WaitReadValid  = 3'd2,
        Write          = 3'd3,
        WaitWriteValid = 3'd4
    } dmi_state_e;

endpackage

// File: rtl/dmi_access_ctrl_timeout_counter.sv
// Response-wait counter for the DMI access controller.
// Only built when DMI_TIMEOUT_EN is defined. Counts enabled cycles from a
// clear; expired_o is high on the enabled cycle where the count reaches
// Limit-1, and the count saturates there.
`ifdef DMI_TIMEOUT_EN
module dmi_timeout_counter #(
    parameter int unsigned Limit = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [15:0] LastCount = 16'(Limit - 1);

    logic [15:0] cnt_q;

    // Count enabled cycles, restart on clear, hold at the last count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && (cnt_q != LastCount)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign expired_o = enable_i && (cnt_q == LastCount);

endmodule
`endif

// File: rtl/dmi_access_ctrl.sv
// DMI access controller between the JTAG DTM DMI register and the debug
// module request/response port. Each accepted Update-DR becomes one DMI
// transaction; read data and sticky dmistat are returned on Capture-DR.
// Optional response timeout: define DMI_TIMEOUT_EN.
//
// Handshake: a request transfers on a cycle where dmi_req_valid_o and
// dmi_req_ready_i are both high; valid and payload hold until then. A
// response transfers on a cycle where dmi_resp_valid_i and
// dmi_resp_ready_o are both high.
module dmi_access_ctrl
    import dm::*;
#(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        update_i,
    input  logic        capture_i,
    input  logic [40:0] dr_i,
    output logic [40:0] dr_o,
    input  logic        dmi_reset_i,
    input  logic        dmi_hard_reset_i,
    output dmi_req_t    dmi_req_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    input  dmi_resp_t   dmi_resp_i,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    output logic [1:0]  dmistat_o
);

    dmi_state_e  state_q, state_d;
    logic [6:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] wdata_q, wdata_d;
    dmi_error_e  error_q, error_d;
    logic [40:0] dr_q;
    dmi_dr_t     dr;
    logic        timeout;

    assign dr = dmi_dr_t'(dr_i);

`ifdef DMI_TIMEOUT_EN
    logic in_wait;
    assign in_wait = (state_q == WaitReadValid) || (state_q == WaitWriteValid);

    dmi_timeout_counter #(
        .Limit(TimeoutCycles)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (!in_wait),
        .enable_i (in_wait),
        .expired_o(timeout)
    );
`else
    logic [15:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 16'(TimeoutCycles);
    assign timeout = 1'b0;
`endif

    // Next-state, request/response handshake and sticky error update.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        data_d           = data_q;
        wdata_d          = wdata_q;
        error_d          = error_q;
        dmi_req_valid_o  = 1'b0;
        dmi_resp_ready_o = 1'b1;
        dmi_req_o        = '0;

        unique case (state_q)
            Idle: begin
                // Stray responses are accepted and dropped here.
                if (update_i && (error_q == DMINoError) &&
                    !dmi_reset_i && !dmi_hard_reset_i) begin
                    if (dr.op == DTM_READ) begin
                        addr_d  = dr.addr;
                        state_d = Read;
                    end else if (dr.op == DTM_WRITE) begin
                        addr_d  = dr.addr;
                        wdata_d = dr.data;
                        state_d = Write;
                    end
                end
            end
            Read: begin
                dmi_req_valid_o  = 1'b1;
                dmi_resp_ready_o = 1'b0;
                dmi_req_o.addr   = addr_q;
                dmi_req_o.op     = DTM_READ;
                if (dmi_req_ready_i) begin
                    state_d = WaitReadValid;
                end
            end
            Write: begin
                dmi_req_valid_o  = 1'b1;
                dmi_resp_ready_o = 1'b0;
                dmi_req_o.addr   = addr_q;
                dmi_req_o.op     = DTM_WRITE;
                dmi_req_o.data   = wdata_q;
                if (dmi_req_ready_i) begin
                    state_d = WaitWriteValid;
                end
            end
            WaitReadValid: begin
                if (dmi_resp_valid_i) begin
                    data_d  = dmi_resp_i.data;
                    state_d = Idle;
                    if (dmi_resp_i.resp != DTM_SUCCESS) begin
                        error_d = DMIFailed;
                    end
                end else if (timeout) begin
                    error_d = DMIFailed;
                    state_d = Idle;
                end
            end
            WaitWriteValid: begin
                if (dmi_resp_valid_i) begin
                    state_d = Idle;
                    if (dmi_resp_i.resp != DTM_SUCCESS) begin
                        error_d = DMIFailed;
                    end
                end else if (timeout) begin
                    error_d = DMIFailed;
                    state_d = Idle;
                end
            end
            default: begin
                state_d = Idle;
            end
        endcase

        // TAP activity during a transaction: busy overrides a same-cycle failure.
        if ((update_i || capture_i) && (state_q != Idle)) begin
            error_d = DMIBusy;
        end
        // Clears win over any error raised in the same cycle.
        if (dmi_reset_i) begin
            error_d = DMINoError;
        end
        if (dmi_hard_reset_i) begin
            error_d = DMINoError;
            state_d = Idle;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= Idle;
            addr_q  <= '0;
            data_q  <= '0;
            wdata_q <= '0;
            error_q <= DMINoError;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wdata_q <= wdata_d;
            error_q <= error_d;
        end
    end

    // Capture-DR snapshot of address, read data and status.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dr_q <= '0;
        end else if (capture_i) begin
            dr_q <= {addr_q, data_q, error_q};
        end
    end

    assign dr_o      = dr_q;
    assign dmistat_o = error_q;

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Directed testbench for dmi_access_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are checked at
// that same point, away from the active edge.
module tb_dmi_access_ctrl;
    import dm::*;

    logic        clk;
    logic        rst_ni;
    logic        update_i;
    logic        capture_i;
    logic [40:0] dr_i;
    logic [40:0] dr_o;
    logic        dmi_reset_i;
    logic        dmi_hard_reset_i;
    dmi_req_t    dmi_req_o;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i;
    dmi_resp_t   dmi_resp_i;
    logic        dmi_resp_valid_i;
    logic        dmi_resp_ready_o;
    logic [1:0]  dmistat_o;

    int checks = 0;
    int errors = 0;

    dmi_access_ctrl #(
        .TimeoutCycles(8)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .update_i        (update_i),
        .capture_i       (capture_i),
        .dr_i            (dr_i),
        .dr_o            (dr_o),
        .dmi_reset_i     (dmi_reset_i),
        .dmi_hard_reset_i(dmi_hard_reset_i),
        .dmi_req_o       (dmi_req_o),
        .dmi_req_valid_o (dmi_req_valid_o),
        .dmi_req_ready_i (dmi_req_ready_i),
        .dmi_resp_i      (dmi_resp_i),
        .dmi_resp_valid_i(dmi_resp_valid_i),
        .dmi_resp_ready_o(dmi_resp_ready_o),
        .dmistat_o       (dmistat_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        dr_i     = {a, d, op};
        update_i = 1'b1;
        cyc();
        update_i = 1'b0;
    endtask

    task automatic do_capture();
        capture_i = 1'b1;
        cyc();
        capture_i = 1'b0;
    endtask

    task automatic do_resp(input logic [31:0] d, input logic [1:0] r);
        dmi_resp_i       = {d, r};
        dmi_resp_valid_i = 1'b1;
        cyc();
        dmi_resp_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        cyc();
        cyc();
        rst_ni = 1'b1;
        checks++; if (dmi_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", dmi_req_valid_o); end
        checks++; if (dmi_resp_ready_o !== 1'b1) begin errors++; $display("FAIL reset_resp_ready got %b exp 1", dmi_resp_ready_o); end
        checks++; if (dr_o !== 41'h0) begin errors++; $display("FAIL reset_dr got %h exp 0", dr_o); end
        checks++; if (dmistat_o !== 2'd0) begin errors++; $display("FAIL reset_dmistat got %0d exp 0", dmistat_o); end
        checks++; if (dut.state_q !== Idle) begin errors++; $display("FAIL reset_state got %0d exp Idle", dut.state_q); end
    endtask

    task automatic test_read();
        do_update(7'h11, 32'hDEADBEEF, 2'd1);
        checks++; if (dmi_req_valid_o !== 1'b1) begin errors++; $display("FAIL read_req_valid got %b exp 1", dmi_req_valid_o); end
        checks++; if (dmi_req_o !== {7'h11, 2'd1, 32'h0}) begin errors++; $display("FAIL read_req_payload got %h exp %h", dmi_req_o, {7'h11, 2'd1, 32'h0}); end
        checks++; if (dmi_resp_ready_o !== 1'b0) begin errors++; $display("FAIL read_resp_ready got %b exp 0", dmi_resp_ready_o); end
        dmi_req_ready_i = 1'b1;
        cyc();
        dmi_req_ready_i = 1'b0;
        checks++; if (dut.state_q !== WaitReadValid) begin errors++; $display("FAIL read_wait_state got %0d exp WaitReadValid", dut.state_q); end
        checks++; if (dmi_req_valid_o !== 1'b0) begin errors++; $display("FAIL read_valid_drop got %b exp 0", dmi_req_valid_o); end
        do_resp(32'h00030382, 2'd0);
        checks++; if (dut.state_q !== Idle) begin errors++; $display("FAIL read_idle got %0d exp Idle", dut.state_q); end
        do_capture();
        checks++; if (dr_o !== {7'h11, 32'h00030382, 2'd0}) begin errors++; $display("FAIL read_capture got %h exp %h", dr_o, {7'h11, 32'h00030382, 2'd0}); end
    endtask

    task automatic test_write();
        do_update(7'h10, 32'h80000001, 2'd2);
        for (int i = 0; i < 4; i++) begin
            checks++; if (dmi_req_valid_o !== 1'b1 || dmi_req_o !== {7'h10, 2'd2, 32'h80000001}) begin errors++; $display("FAIL write_hold_%0d got v=%b %h exp v=1 %h", i, dmi_req_valid_o, dmi_req_o, {7'h10, 2'd2, 32'h80000001}); end
            cyc();
        end
        dmi_req_ready_i = 1'b1;
        checks++; if (dmi_req_valid_o !== 1'b1 || dmi_req_o !== {7'h10, 2'd2, 32'h80000001}) begin errors++; $display("FAIL write_handshake got v=%b %h exp v=1 %h", dmi_req_valid_o, dmi_req_o, {7'h10, 2'd2, 32'h80000001}); end
        cyc();
        dmi_req_ready_i = 1'b0;
        checks++; if (dut.state_q !== WaitWriteValid) begin errors++; $display("FAIL write_wait_state got %0d exp WaitWriteValid", dut.state_q); end
        do_resp(32'h0BADF00D, 2'd0);
        checks++; if (dut.state_q !== Idle || dmistat_o !== 2'd0) begin errors++; $display("FAIL write_done got state=%0d stat=%0d exp Idle/0", dut.state_q, dmistat_o); end
        do_capture();
        checks++; if (dr_o !== {7'h10, 32'h00030382, 2'd0}) begin errors++; $display("FAIL write_capture got %h exp %h", dr_o, {7'h10, 32'h00030382, 2'd0}); end
    endtask

    task automatic test_busy();
        do_update(7'h05, 32'h0, 2'd1);
        dmi_req_ready_i = 1'b1;
        cyc();
        dmi_req_ready_i = 1'b0;
        do_update(7'h06, 32'h1, 2'd2);
        checks++; if (dmistat_o !== 2'd3) begin errors++; $display("FAIL busy_stat got %0d exp 3", dmistat_o); end
        checks++; if (dut.state_q !== WaitReadValid || dmi_req_valid_o !== 1'b0) begin errors++; $display("FAIL busy_no_second_req got state=%0d v=%b exp WaitReadValid/0", dut.state_q, dmi_req_valid_o); end
        do_resp(32'h12345678, 2'd0);
        checks++; if (dut.state_q !== Idle || dmistat_o !== 2'd3) begin errors++; $display("FAIL busy_sticky got state=%0d stat=%0d exp Idle/3", dut.state_q, dmistat_o); end
        do_update(7'h06, 32'h1, 2'd2);
        checks++; if (dut.state_q !== Idle || dmi_req_valid_o !== 1'b0) begin errors++; $display("FAIL busy_update_ignored got state=%0d v=%b exp Idle/0", dut.state_q, dmi_req_valid_o); end
        dmi_reset_i = 1'b1;
        cyc();
        dmi_reset_i = 1'b0;
        checks++; if (dmistat_o !== 2'd0) begin errors++; $display("FAIL busy_cleared got %0d exp 0", dmistat_o); end
        do_update(7'h07, 32'h0, 2'd1);
        checks++; if (dut.state_q !== Read || dmi_req_o !== {7'h07, 2'd1, 32'h0}) begin errors++; $display("FAIL busy_accept_after_clear got state=%0d %h exp Read %h", dut.state_q, dmi_req_o, {7'h07, 2'd1, 32'h0}); end
        dmi_req_ready_i = 1'b1;
        cyc();
        dmi_req_ready_i = 1'b0;
        do_resp(32'hCAFEF00D, 2'd0);
        do_capture();
        checks++; if (dr_o !== {7'h07, 32'hCAFEF00D, 2'd0}) begin errors++; $display("FAIL busy_capture got %h exp %h", dr_o, {7'h07, 32'hCAFEF00D, 2'd0}); end
    endtask

    task automatic test_failed();
        do_update(7'h02, 32'h00000001, 2'd2);
        dmi_req_ready_i = 1'b1;
        cyc();
        dmi_req_ready_i = 1'b0;
        do_resp(32'h0, 2'd2);
        checks++; if (dmistat_o !== 2'd2 || dut.state_q !== Idle) begin errors++; $display("FAIL failed_resp got stat=%0d state=%0d exp 2/Idle", dmistat_o, dut.state_q); end
        do_update(7'h02, 32'h00000001, 2'd2);
        checks++; if (dut.state_q !== Idle || dmistat_o !== 2'd2) begin errors++; $display("FAIL failed_update_ignored got state=%0d stat=%0d exp Idle/2", dut.state_q, dmistat_o); end
        dmi_reset_i = 1'b1;
        cyc();
        dmi_reset_i = 1'b0;
    endtask

    task automatic test_hard_reset();
        do_update(7'h03, 32'h0, 2'd1);
        checks++; if (dmi_req_valid_o !== 1'b1) begin errors++; $display("FAIL hard_pre_valid got %b exp 1", dmi_req_valid_o); end
        dmi_hard_reset_i = 1'b1;
        cyc();
        dmi_hard_reset_i = 1'b0;
        checks++; if (dmi_req_valid_o !== 1'b0 || dut.state_q !== Idle) begin errors++; $display("FAIL hard_drop got v=%b state=%0d exp 0/Idle", dmi_req_valid_o, dut.state_q); end
        do_resp(32'hFFFFFFFF, 2'd2);
        checks++; if (dut.state_q !== Idle || dmistat_o !== 2'd0) begin errors++; $display("FAIL hard_stray got state=%0d stat=%0d exp Idle/0", dut.state_q, dmistat_o); end
        do_capture();
        checks++; if (dr_o !== {7'h03, 32'hCAFEF00D, 2'd0}) begin errors++; $display("FAIL hard_capture got %h exp %h", dr_o, {7'h03, 32'hCAFEF00D, 2'd0}); end
    endtask

    task automatic test_reset_vs_update();
        dmi_reset_i = 1'b1;
        do_update(7'h09, 32'h0, 2'd1);
        dmi_reset_i = 1'b0;
        checks++; if (dut.state_q !== Idle) begin errors++; $display("FAIL reset_wins_update got %0d exp Idle", dut.state_q); end
        dmi_hard_reset_i = 1'b1;
        do_update(7'h09, 32'h5, 2'd2);
        dmi_hard_reset_i = 1'b0;
        checks++; if (dut.state_q !== Idle) begin errors++; $display("FAIL hard_wins_update got %0d exp Idle", dut.state_q); end
    endtask

    task automatic test_timeout();
        do_update(7'h0A, 32'h0, 2'd1);
        dmi_req_ready_i = 1'b1;
        cyc();
        dmi_req_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        checks++; if (dut.state_q !== WaitReadValid) begin errors++; $display("FAIL timeout_still_wait got %0d exp WaitReadValid", dut.state_q); end
        cyc();
        checks++; if (dmistat_o !== 2'd2 || dut.state_q !== Idle) begin errors++; $display("FAIL timeout_expire got stat=%0d state=%0d exp 2/Idle", dmistat_o, dut.state_q); end
        dmi_reset_i = 1'b1;
        cyc();
        dmi_reset_i = 1'b0;
        do_update(7'h0B, 32'h0, 2'd1);
        dmi_req_ready_i = 1'b1;
        cyc();
        dmi_req_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        do_resp(32'h00000055, 2'd0);
        checks++; if (dmistat_o !== 2'd0 || dut.state_q !== Idle) begin errors++; $display("FAIL timeout_resp_wins got stat=%0d state=%0d exp 0/Idle", dmistat_o, dut.state_q); end
        do_capture();
        checks++; if (dr_o !== {7'h0B, 32'h00000055, 2'd0}) begin errors++; $display("FAIL timeout_capture got %h exp %h", dr_o, {7'h0B, 32'h00000055, 2'd0}); end
    endtask

    // Stimulus sequence
    initial begin
        rst_ni           = 1'b0;
        update_i         = 1'b0;
        capture_i        = 1'b0;
        dr_i             = '0;
        dmi_reset_i      = 1'b0;
        dmi_hard_reset_i = 1'b0;
        dmi_req_ready_i  = 1'b0;
        dmi_resp_i       = '0;
        dmi_resp_valid_i = 1'b0;
        #1;
        test_reset();
        test_read();
        test_write();
        test_busy();
        test_failed();
        test_hard_reset();
        test_reset_vs_update();
`ifdef DMI_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
